// File: rtl/dice_pkg.sv
// Shared types and constants for the dice scoreboard: FSM states, seven-segment
// glyphs ({a,b,c,d,e,f,g}, active-high) and one-hot player helpers.
package dice_pkg;

    localparam int PLAYER_COUNT = 4;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [PLAYER_COUNT-1:0] one_hot(input logic [1:0] idx);
        return PLAYER_COUNT'(1) << idx;
    endfunction

    function automatic logic [1:0] hot_index(input logic [PLAYER_COUNT-1:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/dice_seg_scan.sv
// Four-digit multiplexed seven-segment driver: player number on digit 3,
// two-digit score on digits 1/0, digit 2 blank.
module dice_seg_scan
    import dice_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] score,
    input  logic [1:0] player,
    input  logic       dp_en,
    output logic [7:0] seg,
    output logic [3:0] digit_sel
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count;
    logic [5:0]    rem;
    logic [2:0]    tens;
    logic [3:0]    player_num;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count     <= '0;
            digit_sel <= 4'b0001;
        end else if (count == LAST) begin
            count     <= '0;
            digit_sel <= {digit_sel[2:0], digit_sel[3]};
        end else begin
            count <= count + CW'(1);
        end
    end

    // Score is at most 63, so six conditional subtractions cover every tens value.
    always_comb begin
        rem  = score;
        tens = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 3'd1;
            end
        end
    end

    assign player_num = {2'b00, player} + 4'd1;

    always_comb begin
        seg = {SEG_BLANK, 1'b0};
        case (digit_sel)
            4'b0001: seg = {seg_digit(rem[3:0]), 1'b0};
            4'b0010: seg = (tens == 3'd0) ? {SEG_BLANK, 1'b0} : {seg_digit({1'b0, tens}), 1'b0};
            4'b1000: seg = {seg_digit(player_num), dp_en};
            default: seg = {SEG_BLANK, 1'b0};
        endcase
    end

endmodule

// File: rtl/dice_scoreboard.sv
// Dice game scoreboard: accumulates rolls per player, rotates the one-hot turn
// (a 6 earns another roll), latches a winner at TARGET and drives the display.
module dice_scoreboard
    import dice_pkg::*;
#(
    parameter int PLAYERS  = 4,
    parameter int TARGET   = 30,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       roll_valid,
    input  logic [2:0] roll_value,
    input  logic       new_game,
    output logic [3:0] turn,
    output logic [3:0] winner,
    output logic       game_over,
    output logic       roll_err,
    output logic [7:0] seg,
    output logic [3:0] digit_sel
);

    state_t                   state, state_next;
    logic [PLAYERS-1:0][5:0]  scores;
    logic [1:0]               cur, disp_player;
    logic                     roll_ok, last_six, reached;
    logic [6:0]               sum;
    logic [5:0]               sum_sat;

    assign cur     = hot_index(turn);
    assign roll_ok = (roll_value != 3'd0) && (roll_value != 3'd7);
    assign sum     = {1'b0, scores[cur]} + {4'b0000, roll_value};
    assign sum_sat = sum[6] ? 6'd63 : sum[5:0];
    assign reached = scores[cur] >= 6'(TARGET);

    always_ff @(posedge clock) begin
        if (!reset) state <= WAIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (new_game) begin
            state_next = WAIT;
        end else begin
            case (state)
                WAIT:    if (roll_valid && roll_ok) state_next = CHECK;
                CHECK:   state_next = reached ? DONE : WAIT;
                DONE:    state_next = DONE;
                default: state_next = WAIT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            scores    <= '0;
            turn      <= one_hot(2'd0);
            winner    <= '0;
            game_over <= 1'b0;
            roll_err  <= 1'b0;
            last_six  <= 1'b0;
        end else begin
            roll_err <= 1'b0;
            if (new_game) begin
                scores    <= '0;
                turn      <= one_hot(2'd0);
                winner    <= '0;
                game_over <= 1'b0;
            end else begin
                case (state)
                    WAIT: begin
                        if (roll_valid) begin
                            if (roll_ok) begin
                                scores[cur] <= sum_sat;
                                last_six    <= (roll_value == 3'd6);
                            end else begin
                                roll_err <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        // scores[cur] already holds the updated total here.
                        if (reached) begin
                            winner    <= turn;
                            game_over <= 1'b1;
                        end else if (!last_six) begin
                            turn <= {turn[2:0], turn[3]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign disp_player = (state == DONE) ? hot_index(winner) : cur;

    dice_seg_scan #(.SCAN_DIV(SCAN_DIV)) u_seg_scan (
        .clock     (clock),
        .reset     (reset),
        .score     (scores[disp_player]),
        .player    (disp_player),
        .dp_en     (state == DONE),
        .seg       (seg),
        .digit_sel (digit_sel)
    );

endmodule

// File: tb/tb_dice_scoreboard.sv
// Scoreboard bench: driver runs a game-level model and queues expected outputs;
// a monitor pops one expectation per clock and compares all observable outputs.
module tb_dice_scoreboard;

    localparam int TGT = 30;
    localparam int SD  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       roll_valid = 1'b0;
    logic [2:0] roll_value = 3'd0;
    logic       new_game = 1'b0;
    logic [3:0] turn, winner, digit_sel;
    logic       game_over, roll_err;
    logic [7:0] seg;

    always #5 clock = ~clock;

    dice_scoreboard #(.PLAYERS(4), .TARGET(TGT), .SCAN_DIV(SD)) dut (
        .clock      (clock),
        .reset      (reset),
        .roll_valid (roll_valid),
        .roll_value (roll_value),
        .new_game   (new_game),
        .turn       (turn),
        .winner     (winner),
        .game_over  (game_over),
        .roll_err   (roll_err),
        .seg        (seg),
        .digit_sel  (digit_sel)
    );

    typedef struct {
        logic [3:0] turn;
        logic [3:0] winner;
        logic       go;
        logic       err;
        logic [3:0] dsel;
        logic [7:0] seg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Game model: plain integers for scores, player index and winner.
    int sc[4];
    int cur = 0, win = -1, k = 0, last = 0;
    bit pend = 0, err = 0;

    logic [6:0] segtab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    function automatic logic [7:0] exp_seg(input int d, input int p, input int s, input bit done);
        int t, u;
        t = s / 10;
        u = s % 10;
        case (d)
            0:       return {segtab[u], 1'b0};
            1:       return (t == 0) ? 8'h00 : {segtab[t], 1'b0};
            2:       return 8'h00;
            default: return {segtab[p + 1], done};
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit ng, input bit rv, input int val);
        if (!rst) begin
            for (int i = 0; i < 4; i++) sc[i] = 0;
            cur = 0; win = -1; pend = 0; err = 0; k = 0;
        end else begin
            k++;
            err = 0;
            if (ng) begin
                for (int i = 0; i < 4; i++) sc[i] = 0;
                cur = 0; win = -1; pend = 0;
            end else if (pend) begin
                pend = 0;
                if (sc[cur] >= TGT) win = cur;
                else if (last != 6) cur = (cur + 1) % 4;
            end else if (win < 0 && rv) begin
                if (val >= 1 && val <= 6) begin
                    sc[cur] = (sc[cur] + val > 63) ? 63 : sc[cur] + val;
                    last = val;
                    pend = 1;
                end else begin
                    err = 1;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit ng, input bit rv, input int val);
        exp_t e;
        int   p;
        @(negedge clock);
        reset      = rst;
        new_game   = ng;
        roll_valid = rv;
        roll_value = 3'(val);
        model_edge(rst, ng, rv, val);
        p        = (win >= 0) ? win : cur;
        e.turn   = 4'(1 << cur);
        e.winner = (win >= 0) ? 4'(1 << win) : 4'b0000;
        e.go     = (win >= 0);
        e.err    = err;
        e.dsel   = 4'(1 << ((k / SD) % 4));
        e.seg    = exp_seg((k / SD) % 4, p, sc[p], win >= 0);
        q.push_back(e);
    endtask

    task automatic roll(input int val);
        step(1, 0, 1, val);
        step(1, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("turn",      {4'h0, turn},      {4'h0, e.turn});
                chk("winner",    {4'h0, winner},    {4'h0, e.winner});
                chk("game_over", {7'h0, game_over}, {7'h0, e.go});
                chk("roll_err",  {7'h0, roll_err},  {7'h0, e.err});
                chk("digit_sel", {4'h0, digit_sel}, {4'h0, e.dsel});
                chk("seg",       seg,               e.seg);
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 4; i++) sc[i] = 0;
        // Reset held three cycles
        repeat (3) step(0, 0, 0, 0);
        idle(2);
        // Rolls 3 then 4: P1=3, P2=4
        roll(3);
        roll(4);
        idle(12);
        // Six keeps the turn, then 2 passes it on
        step(1, 1, 0, 0);
        roll(6);
        roll(2);
        idle(4);
        // Illegal rolls, then a strobe during CHECK
        roll(0);
        roll(7);
        step(1, 0, 1, 1);
        step(1, 0, 1, 5);
        idle(4);
        // P1 to 28, others roll 1, then P1 rolls 5 and wins with 33
        step(1, 1, 0, 0);
        roll(6); roll(6); roll(6); roll(6); roll(4);
        roll(1); roll(1); roll(1);
        roll(5);
        roll(3); roll(6);
        idle(14);
        // new_game from DONE, then new_game coincident with a roll
        step(1, 1, 0, 0);
        roll(2);
        step(1, 1, 1, 4);
        idle(4);
        // Reset asserted during CHECK
        step(1, 0, 1, 3);
        step(0, 0, 0, 0);
        idle(6);
        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            bit rst, ng, rv;
            rst = ($urandom_range(0, 299) != 0);
            ng  = ($urandom_range(0, 149) == 0);
            rv  = ($urandom_range(0, 1) == 1);
            step(rst, ng, rv, int'($urandom_range(0, 7)));
        end
        step(1, 0, 0, 0);
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
